// File: rtl/memory_bus_arbiter.sv
// Arbitrates NUM_PORTS upstream requesters onto one downstream request channel
// through a single-entry output register, and routes ID-tagged responses back.
module memory_bus_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int BASE_ID         = 0,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] upMsAddress,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    upMsData,
  input  logic [NUM_PORTS-1:0]               upMsWrite,
  input  logic [NUM_PORTS-1:0]               upMsValid,
  output logic [NUM_PORTS-1:0]               upMsReady,
  output logic [DATA_WIDTH-1:0]              upSmData,
  output logic [NUM_PORTS-1:0]               upSmValid,
  input  logic [NUM_PORTS-1:0]               upSmReady,
  output logic [MASTER_ID_WIDTH-1:0]         msID,
  output logic [ADDRESS_WIDTH-1:0]           msAddress,
  output logic [DATA_WIDTH-1:0]              msData,
  output logic                               msWrite,
  output logic                               msValid,
  input  logic                               msReady,
  input  logic [MASTER_ID_WIDTH-1:0]         smID,
  input  logic [DATA_WIDTH-1:0]              smData,
  input  logic                               smValid,
  output logic                               smReady,
  output logic                               dropped
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           grant_idx;
  logic [PTR_W-1:0]           cand;
  logic                       grant_any;
  logic                       can_accept;
  logic                       take;
  int                         arb_start;

  logic                       vld_p1;
  logic [MASTER_ID_WIDTH-1:0] id_p1;
  logic [ADDRESS_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]      data_p1;
  logic                       wr_p1;

  logic                       sm_hit;
  logic [PTR_W-1:0]           sm_port;
  logic                       drop_now;
  logic                       dropped_p1;

  // Arbitration: round-robin searches from the port after the last grant,
  // fixed priority always searches from port 0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    arb_start = (ROUND_ROBIN != 0) ? ((int'(rr_ptr) + 1) % NUM_PORTS) : 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((arb_start + k) % NUM_PORTS);
      if (!grant_any && upMsValid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The register is free when empty or when its current entry drains this cycle.
  assign can_accept = reset && (!vld_p1 || msReady);
  assign take       = can_accept && grant_any;
  assign upMsReady  = take ? (ONE_HOT0 << grant_idx) : '0;

  // Stage p1: downstream request register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
      wr_p1   <= 1'b0;
      rr_ptr  <= PTR_W'(NUM_PORTS - 1);
    end else begin
      if (take) begin
        vld_p1  <= 1'b1;
        id_p1   <= MASTER_ID_WIDTH'(BASE_ID + int'(grant_idx));
        addr_p1 <= upMsAddress[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        data_p1 <= upMsData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        wr_p1   <= upMsWrite[grant_idx];
        rr_ptr  <= grant_idx;
      end else if (msReady) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign msValid   = vld_p1;
  assign msID      = id_p1;
  assign msAddress = addr_p1;
  assign msData    = data_p1;
  assign msWrite   = wr_p1;

  // Response decode: match smID against each port's bus ID.
  always_comb begin
    sm_hit  = 1'b0;
    sm_port = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (smID == MASTER_ID_WIDTH'(BASE_ID + i)) begin
        sm_hit  = 1'b1;
        sm_port = PTR_W'(i);
      end
    end
  end

  assign upSmData  = smData;
  assign upSmValid = (sm_hit && smValid) ? (ONE_HOT0 << sm_port) : '0;
  // Unroutable responses are always accepted so they cannot block the channel.
  assign smReady   = reset && (sm_hit ? upSmReady[sm_port] : 1'b1);
  assign drop_now  = reset && smValid && !sm_hit;

  // Stage p1: drop indication
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropped_p1 <= 1'b0;
    end else begin
      dropped_p1 <= drop_now;
    end
  end

  assign dropped = dropped_p1;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: a round-robin and a fixed-priority instance.
module tb_memory_bus_arbiter;

  localparam int NP = 4;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int IW = 8;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
  } req_t;

  logic clock, reset;

  logic [NP*AW-1:0] upMsAddress, f_upMsAddress;
  logic [NP*DW-1:0] upMsData, f_upMsData;
  logic [NP-1:0]    upMsWrite, f_upMsWrite, upMsValid, f_upMsValid;
  logic [NP-1:0]    upMsReady, f_upMsReady, upSmValid, f_upSmValid;
  logic [NP-1:0]    upSmReady, f_upSmReady;
  logic [DW-1:0]    upSmData, f_upSmData;
  logic [IW-1:0]    msID, f_msID, smID, f_smID;
  logic [AW-1:0]    msAddress, f_msAddress;
  logic [DW-1:0]    msData, f_msData, smData, f_smData;
  logic             msWrite, f_msWrite, msValid, f_msValid, msReady, f_msReady;
  logic             smValid, f_smValid, smReady, f_smReady, dropped, f_dropped;

  req_t q_rr[$];
  req_t q_fp[$];
  req_t e_rr, e_fp;
  int   n_chk  = 0;
  int   n_fail = 0;

  memory_bus_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                       .MASTER_ID_WIDTH(IW), .BASE_ID(0), .ROUND_ROBIN(1)) dut_rr (
    .clock(clock), .reset(reset),
    .upMsAddress(upMsAddress), .upMsData(upMsData), .upMsWrite(upMsWrite),
    .upMsValid(upMsValid), .upMsReady(upMsReady),
    .upSmData(upSmData), .upSmValid(upSmValid), .upSmReady(upSmReady),
    .msID(msID), .msAddress(msAddress), .msData(msData), .msWrite(msWrite),
    .msValid(msValid), .msReady(msReady),
    .smID(smID), .smData(smData), .smValid(smValid), .smReady(smReady),
    .dropped(dropped));

  memory_bus_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                       .MASTER_ID_WIDTH(IW), .BASE_ID(0), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset),
    .upMsAddress(f_upMsAddress), .upMsData(f_upMsData), .upMsWrite(f_upMsWrite),
    .upMsValid(f_upMsValid), .upMsReady(f_upMsReady),
    .upSmData(f_upSmData), .upSmValid(f_upSmValid), .upSmReady(f_upSmReady),
    .msID(f_msID), .msAddress(f_msAddress), .msData(f_msData), .msWrite(f_msWrite),
    .msValid(f_msValid), .msReady(f_msReady),
    .smID(f_smID), .smData(f_smData), .smValid(f_smValid), .smReady(f_smReady),
    .dropped(f_dropped));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input int id, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic w);
    req_t r;
    r.id   = IW'(id);
    r.addr = a;
    r.data = d;
    r.wr   = w;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic w);
    upMsAddress[i*AW +: AW] = a;
    upMsData[i*DW +: DW]    = d;
    upMsWrite[i]            = w;
  endtask

  task automatic set_fport(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic w);
    f_upMsAddress[i*AW +: AW] = a;
    f_upMsData[i*DW +: DW]    = d;
    f_upMsWrite[i]            = w;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Monitors: every downstream handshake must match the oldest expected request.
  always @(negedge clock) begin
    if (msValid && msReady) begin
      if (q_rr.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rr_unexpected: got id %0d expected no request", msID);
      end else begin
        e_rr = q_rr.pop_front();
        chk("rr_msID", 64'(msID), 64'(e_rr.id));
        chk("rr_msAddress", 64'(msAddress), 64'(e_rr.addr));
        chk("rr_msData", 64'(msData), 64'(e_rr.data));
        chk("rr_msWrite", 64'(msWrite), 64'(e_rr.wr));
      end
    end
  end

  always @(negedge clock) begin
    if (f_msValid && f_msReady) begin
      if (q_fp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fp_unexpected: got id %0d expected no request", f_msID);
      end else begin
        e_fp = q_fp.pop_front();
        chk("fp_msID", 64'(f_msID), 64'(e_fp.id));
        chk("fp_msAddress", 64'(f_msAddress), 64'(e_fp.addr));
        chk("fp_msData", 64'(f_msData), 64'(e_fp.data));
        chk("fp_msWrite", 64'(f_msWrite), 64'(e_fp.wr));
      end
    end
  end

  logic [NP-1:0] exp_oh;

  initial begin
    reset = 1'b0;
    upMsAddress = '0; upMsData = '0; upMsWrite = '0; upMsValid = '1; upSmReady = '1;
    msReady = 1'b1; smID = 8'd1; smData = '0; smValid = 1'b1;
    f_upMsAddress = '0; f_upMsData = '0; f_upMsWrite = '0; f_upMsValid = '1;
    f_upSmReady = '0; f_msReady = 1'b0; f_smID = '0; f_smData = '0; f_smValid = 1'b0;

    // Reset state, with requests and a response pending to show the gating.
    #3;
    chk("rst_msValid", 64'(msValid), 64'(0));
    chk("rst_msID", 64'(msID), 64'(0));
    chk("rst_msAddress", 64'(msAddress), 64'(0));
    chk("rst_upMsReady", 64'(upMsReady), 64'(0));
    chk("rst_smReady", 64'(smReady), 64'(0));
    chk("rst_dropped", 64'(dropped), 64'(0));
    chk("rst_fp_upMsReady", 64'(f_upMsReady), 64'(0));
    upMsValid = '0; smValid = 1'b0; f_upMsValid = '0;
    tick();
    tick();
    reset = 1'b1;

    // Single write from port 2.
    set_port(2, 32'h100, 24'hABCDEF, 1'b1);
    upMsValid = 4'b0100;
    q_rr.push_back(mk(2, 32'h100, 24'hABCDEF, 1'b1));
    #1 chk("t1_upMsReady", 64'(upMsReady), 64'(4'b0100));
    tick();
    upMsValid = '0;
    chk("t1_msValid", 64'(msValid), 64'(1));
    tick();
    chk("t1_drained", 64'(msValid), 64'(0));

    // Round-robin across all four ports, back to back.
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, AW'(32'h1000 + i), DW'(24'h10 + i), 1'(i % 2));
    upMsValid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      q_rr.push_back(mk(c % 4, AW'(32'h1000 + (c % 4)), DW'(24'h10 + (c % 4)), 1'((c % 4) % 2)));
      exp_oh = 4'b0001 << (c % 4);
      #1 chk("rr_grant", 64'(upMsReady), 64'(exp_oh));
      tick();
    end
    upMsValid = '0;
    tick();
    chk("rr_drained", 64'(msValid), 64'(0));

    // Backpressure: entry from port 1 holds, no grants, then port 3 follows.
    msReady = 1'b0;
    set_port(1, 32'h2222, 24'h333333, 1'b0);
    set_port(3, 32'h3030, 24'h777777, 1'b1);
    upMsValid = 4'b1010;
    q_rr.push_back(mk(1, 32'h2222, 24'h333333, 1'b0));
    #1 chk("bp_first_grant", 64'(upMsReady), 64'(4'b0010));
    tick();
    upMsValid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_msValid", 64'(msValid), 64'(1));
      chk("bp_msID", 64'(msID), 64'(1));
      chk("bp_msAddress", 64'(msAddress), 64'(32'h2222));
      chk("bp_msData", 64'(msData), 64'(24'h333333));
      chk("bp_upMsReady", 64'(upMsReady), 64'(0));
      tick();
    end
    msReady = 1'b1;
    q_rr.push_back(mk(3, 32'h3030, 24'h777777, 1'b1));
    #1 chk("bp_next_grant", 64'(upMsReady), 64'(4'b1000));
    tick();
    upMsValid = '0;
    tick();
    chk("bp_drained", 64'(msValid), 64'(0));

    // Response routing, concurrent with a request from port 0, then a drop.
    smData = 24'h5A5A5A; smID = 8'd1; smValid = 1'b1; upSmReady = 4'b0000;
    #1;
    chk("rsp_upSmValid", 64'(upSmValid), 64'(4'b0010));
    chk("rsp_smReady_lo", 64'(smReady), 64'(0));
    chk("rsp_upSmData", 64'(upSmData), 64'(24'h5A5A5A));
    upSmReady = 4'b1101;
    #1 chk("rsp_smReady_other", 64'(smReady), 64'(0));
    upSmReady = 4'b0010;
    set_port(0, 32'h4444, 24'h0F0F0F, 1'b1);
    upMsValid = 4'b0001;
    q_rr.push_back(mk(0, 32'h4444, 24'h0F0F0F, 1'b1));
    #1;
    chk("rsp_smReady_hi", 64'(smReady), 64'(1));
    chk("rsp_upSmValid2", 64'(upSmValid), 64'(4'b0010));
    chk("rsp_req_grant", 64'(upMsReady), 64'(4'b0001));
    tick();
    upMsValid = '0;
    chk("rsp_no_drop", 64'(dropped), 64'(0));
    smID = 8'd3; upSmReady = 4'b0000;
    #1 chk("rsp_port3", 64'(upSmValid), 64'(4'b1000));
    smID = 8'd7;
    #1;
    chk("drop_upSmValid", 64'(upSmValid), 64'(0));
    chk("drop_smReady", 64'(smReady), 64'(1));
    chk("drop_same_cycle", 64'(dropped), 64'(0));
    tick();
    smValid = 1'b0;
    chk("drop_pulse", 64'(dropped), 64'(1));
    tick();
    chk("drop_cleared", 64'(dropped), 64'(0));

    // Reset while an entry is stalled: it must vanish and never reappear.
    msReady = 1'b0;
    set_port(2, 32'h5555, 24'h121212, 1'b0);
    upMsValid = 4'b0100;
    #1 chk("mid_grant", 64'(upMsReady), 64'(4'b0100));
    tick();
    upMsValid = '0;
    #1 chk("mid_loaded", 64'(msValid), 64'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_msValid", 64'(msValid), 64'(0));
    chk("mid_rst_msID", 64'(msID), 64'(0));
    chk("mid_rst_msAddress", 64'(msAddress), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    msReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("mid_no_replay", 64'(msValid), 64'(0));
      tick();
    end

    // Fixed priority: port 1 beats port 3 every cycle.
    f_msReady = 1'b1;
    set_fport(1, 32'hA1, 24'h0000A1, 1'b0);
    set_fport(3, 32'hA3, 24'h0000A3, 1'b1);
    f_upMsValid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      q_fp.push_back(mk(1, 32'hA1, 24'h0000A1, 1'b0));
      #1 chk("fp_grant1", 64'(f_upMsReady), 64'(4'b0010));
      tick();
    end
    f_upMsValid = 4'b1000;
    q_fp.push_back(mk(3, 32'hA3, 24'h0000A3, 1'b1));
    #1 chk("fp_grant3", 64'(f_upMsReady), 64'(4'b1000));
    tick();
    f_upMsValid = '0;
    tick();
    tick();

    chk("rr_queue_empty", 64'(q_rr.size()), 64'(0));
    chk("fp_queue_empty", 64'(q_fp.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of upstream request/response ports; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 24, data width on both channels.
REQ-003 Parameter ADDRESS_WIDTH, default 32, request address width.
REQ-004 Parameter MASTER_ID_WIDTH, default 8, bus ID width.
REQ-005 Parameter BASE_ID, default 0, bus ID of port 0; port i SHALL use ID BASE_ID+i, and BASE_ID+NUM_PORTS-1 SHALL be < 2^MASTER_ID_WIDTH.
REQ-006 Parameter ROUND_ROBIN, default 1; 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-007 Ports (name  direction  width  meaning):
 clock  in  1  single clock, rising edge
 reset  in  1  asynchronous, active-low reset
 upMsAddress  in  NUM_PORTS*ADDRESS_WIDTH  per-port request address, port i at slice i
 upMsData  in  NUM_PORTS*DATA_WIDTH  per-port write data
 upMsWrite  in  NUM_PORTS  per-port write (1) / read (0)
 upMsValid  in  NUM_PORTS  per-port request valid
 upMsReady  out  NUM_PORTS  per-port request accepted
 upSmData  out  DATA_WIDTH  response data, broadcast to all ports
 upSmValid  out  NUM_PORTS  per-port response valid
 upSmReady  in  NUM_PORTS  per-port response ready
 msID  out  MASTER_ID_WIDTH  downstream request ID
 msAddress  out  ADDRESS_WIDTH  downstream request address
 msData  out  DATA_WIDTH  downstream write data
 msWrite  out  1  downstream write flag
 msValid  out  1  downstream request valid
 msReady  in  1  downstream request ready
 smID  in  MASTER_ID_WIDTH  response ID
 smData  in  DATA_WIDTH  response data
 smValid  in  1  response valid
 smReady  out  1  response ready
 dropped  out  1  one-cycle pulse: unroutable response consumed

Function
REQ-008 Request path SHALL hold a single-entry output register driving msID/msAddress/msData/msWrite/msValid.
REQ-009 Register can accept when empty (msValid=0) or draining (msValid && msReady) in the same cycle.
REQ-010 When it can accept, exactly one requesting port SHALL be granted and only that port's upMsReady SHALL be 1; all others 0; no request -> all 0.
REQ-011 Accepted request SHALL appear on msValid the next cycle with msID=BASE_ID+granted index; latency 1 cycle.
REQ-012 With msReady held 1, throughput SHALL be one request per cycle with no bubbles.
REQ-013 While msValid=1 and msReady=0, all ms* outputs SHALL hold stable and all upMsReady SHALL be 0.
REQ-014 Round-robin: search starts at (last granted + 1) mod NUM_PORTS, wrapping; pointer updates only on a completed upstream handshake.
REQ-015 Fixed priority: lowest-index requesting port always wins; pointer unused.
REQ-016 Response routing is combinational: if smID-BASE_ID in [0,NUM_PORTS), upSmValid[port]=smValid, smReady=upSmReady[port], other upSmValid bits 0.
REQ-017 Out-of-range smID: all upSmValid 0, smReady=1, response discarded; dropped SHALL be 1 in the following cycle only.
REQ-018 upSmData SHALL equal smData at all times.
REQ-019 Request and response paths are independent; a response and request may complete in the same cycle.

Reset
REQ-020 reset=0 SHALL asynchronously clear msValid, msID, msAddress, msData, msWrite, dropped to 0 and set the round-robin pointer to NUM_PORTS-1 (port 0 granted first).
REQ-021 While reset=0, all upMsReady SHALL be 0 and smReady SHALL be 0.
REQ-022 Reset mid-transfer SHALL discard the buffered request; no replay after release.

Verification
REQ-023 Reset release, port 2 requests addr 0x100 write data 0xABCDEF, msReady=1 -> next cycle msValid=1, msID=2, msAddress=0x100, msWrite=1, msData=0xABCDEF.
REQ-024 ROUND_ROBIN=1, all 4 ports request continuously, msReady=1 -> msID sequence 0,1,2,3,0 on consecutive cycles.
REQ-025 ROUND_ROBIN=0, ports 1 and 3 request -> port 1 granted every cycle, port 3 never while port 1 requests.
REQ-026 Request pending, msReady=0 for 5 cycles -> ms* outputs stable, upMsReady all 0; msReady=1 -> handshake, next grant following cycle.
REQ-027 smID=BASE_ID+1, smValid=1, upSmReady[1]=0 then 1 -> upSmValid=0010, smReady follows upSmReady[1]; smID=BASE_ID+7 -> smReady=1, dropped=1 next cycle.
REQ-028 Assert reset=0 while msValid=1, msReady=0 -> msValid=0 immediately; after release no request issued without new upMsValid.
